// File: rtl/music_streamer.sv
// Note sequencer: steps a synchronous note ROM at a programmable tempo and
// feeds the tone generator with a registered period and enable.
module music_streamer #(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned NUM_NOTES     = 1024,
  parameter int unsigned DEFAULT_TEMPO = 5_000_000,
  parameter int unsigned TEMPO_STEP    = 500_000,
  parameter int unsigned MIN_TEMPO     = 500_000,
  parameter int unsigned MAX_TEMPO     = 15_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  play_pause,
  input  logic                  reverse,
  input  logic                  tempo_up,
  input  logic                  tempo_down,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [23:0]           rom_data,
  output logic [23:0]           tone_switch_period,
  output logic                  output_enable,
  output logic                  playing,
  output logic                  reversed
);

  localparam logic [24:0]           StepW    = 25'(TEMPO_STEP);
  localparam logic [24:0]           MinW     = 25'(MIN_TEMPO);
  localparam logic [24:0]           MaxW     = 25'(MAX_TEMPO);
  localparam logic [23:0]           DefTempo = 24'(DEFAULT_TEMPO);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_NOTES - 1);

  typedef enum logic [0:0] {StPaused, StPlaying} state_e;

  state_e                state_q, state_d;
  logic [23:0]           beat_cnt_q, beat_cnt_d;
  logic [23:0]           tempo_q, tempo_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  reversed_q, reversed_d;
  logic [23:0]           period_q;
  logic                  enable_q;
  logic                  beat_done;
  logic [24:0]           tempo_ext, tempo_dec, tempo_inc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StPaused;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: play_pause toggles between the two states
  always_comb begin
    state_d = state_q;
    if (play_pause) begin
      state_d = (state_q == StPlaying) ? StPaused : StPlaying;
    end
  end

  // State-decoded output
  always_comb begin
    playing = (state_q == StPlaying);
  end

  // Beat boundary uses >= so a tempo shrink below the count steps at once
  always_comb begin
    tempo_ext = {1'b0, tempo_q};
    beat_done = (state_q == StPlaying) && ({1'b0, beat_cnt_q} >= (tempo_ext - 25'd1));
  end

  // Next-state datapath: direction, beat counter, address and tempo
  always_comb begin
    reversed_d = reversed_q ^ reverse;
    beat_cnt_d = beat_cnt_q;
    addr_d     = addr_q;
    tempo_d    = tempo_q;
    tempo_dec  = (tempo_ext < (MinW + StepW)) ? MinW : (tempo_ext - StepW);
    tempo_inc  = ((tempo_ext + StepW) > MaxW) ? MaxW : (tempo_ext + StepW);

    if (beat_done) begin
      beat_cnt_d = '0;
      // A reverse pulse on the boundary cycle already steers this step
      if (reversed_d) begin
        addr_d = (addr_q == '0) ? LastAddr : (addr_q - 1'b1);
      end else begin
        addr_d = (addr_q == LastAddr) ? '0 : (addr_q + 1'b1);
      end
    end else if (state_q == StPlaying) begin
      beat_cnt_d = beat_cnt_q + 24'd1;
    end

    if (tempo_up && !tempo_down) begin
      tempo_d = tempo_dec[23:0];
    end else if (tempo_down && !tempo_up) begin
      tempo_d = tempo_inc[23:0];
    end
  end

  // Sequencer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      tempo_q    <= DefTempo;
      addr_q     <= '0;
      reversed_q <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      tempo_q    <= tempo_d;
      addr_q     <= addr_d;
      reversed_q <= reversed_d;
    end
  end

  // Tone generator outputs follow the ROM word one cycle after it is valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= '0;
      enable_q <= 1'b0;
    end else begin
      period_q <= rom_data;
      enable_q <= (state_q == StPlaying) && (rom_data != '0);
    end
  end

  assign rom_addr           = addr_q;
  assign tone_switch_period = period_q;
  assign output_enable      = enable_q;
  assign reversed           = reversed_q;

endmodule

// File: tb/tb_music_streamer.sv
// Directed bench for music_streamer with a small tempo and a 4-entry ROM.
module tb_music_streamer;

  logic        clk;
  logic        rst;
  logic        play_pause;
  logic        reverse;
  logic        tempo_up;
  logic        tempo_down;
  logic [1:0]  rom_addr;
  logic [23:0] rom_data;
  logic [23:0] tone_switch_period;
  logic        output_enable;
  logic        playing;
  logic        reversed;

  logic [23:0] rom_mem [4];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int chg_cyc  = 0;

  music_streamer #(
    .ADDR_WIDTH   (2),
    .NUM_NOTES    (4),
    .DEFAULT_TEMPO(10),
    .TEMPO_STEP   (4),
    .MIN_TEMPO    (2),
    .MAX_TEMPO    (18)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .play_pause        (play_pause),
    .reverse           (reverse),
    .tempo_up          (tempo_up),
    .tempo_down        (tempo_down),
    .rom_addr          (rom_addr),
    .rom_data          (rom_data),
    .tone_switch_period(tone_switch_period),
    .output_enable     (output_enable),
    .playing           (playing),
    .reversed          (reversed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM model, one cycle latency
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Wait for the next address change and check its value and note length
  task automatic wait_addr(input logic [1:0] exp_addr, input int exp_len, input string name);
    logic [1:0] start;
    int n;
    start = rom_addr;
    n = 0;
    do begin
      tick();
      n++;
    end while (rom_addr == start && n < 100);
    n_checks++;
    if (rom_addr !== exp_addr) begin
      n_fail++;
      $display("FAIL %s addr: got %0d expected %0d", name, rom_addr, exp_addr);
    end
    n_checks++;
    if (cyc - chg_cyc != exp_len) begin
      n_fail++;
      $display("FAIL %s length: got %0d expected %0d", name, cyc - chg_cyc, exp_len);
    end
    chg_cyc = cyc;
  endtask

  // Called right after an address change: period lags the address by 2 clocks
  task automatic check_tone(input logic [1:0] prev_addr, input logic [1:0] new_addr);
    logic exp_oe;
    tick();
    n_checks++;
    if (tone_switch_period !== rom_mem[prev_addr]) begin
      n_fail++;
      $display("FAIL tone_lag: got %0d expected %0d", tone_switch_period, rom_mem[prev_addr]);
    end
    tick();
    exp_oe = (rom_mem[new_addr] != 24'd0);
    n_checks++;
    if (tone_switch_period !== rom_mem[new_addr]) begin
      n_fail++;
      $display("FAIL tone_new: got %0d expected %0d", tone_switch_period, rom_mem[new_addr]);
    end
    n_checks++;
    if (output_enable !== exp_oe) begin
      n_fail++;
      $display("FAIL oe_new addr %0d: got %b expected %b", new_addr, output_enable, exp_oe);
    end
  endtask

  task automatic pulse_play();
    play_pause = 1'b1;
    tick();
    play_pause = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if (rom_addr !== 2'd0 || tone_switch_period !== 24'd0 || output_enable !== 1'b0 ||
        playing !== 1'b0 || reversed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: addr %0d tone %0d oe %b playing %b reversed %b",
               rom_addr, tone_switch_period, output_enable, playing, reversed);
    end
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_checks++;
      if (rom_addr !== 2'd0 || output_enable !== 1'b0 || playing !== 1'b0) begin
        n_fail++;
        $display("FAIL paused_hold cycle %0d: addr %0d oe %b playing %b expected 0 0 0",
                 i, rom_addr, output_enable, playing);
      end
    end
    n_checks++;
    if (tone_switch_period !== 24'd100) begin
      n_fail++;
      $display("FAIL paused_tone: got %0d expected 100", tone_switch_period);
    end
  endtask

  task automatic test_play_wrap();
    pulse_play();
    chg_cyc = cyc;
    n_checks++;
    if (playing !== 1'b1 || output_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL play_start: playing %b oe %b expected 1 0", playing, output_enable);
    end
    tick();
    n_checks++;
    if (output_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL oe_follow: got %b expected 1", output_enable);
    end
    wait_addr(2'd1, 10, "play_1");
    check_tone(2'd0, 2'd1);
    wait_addr(2'd2, 10, "play_2");
    check_tone(2'd1, 2'd2);
    wait_addr(2'd3, 10, "play_3");
    check_tone(2'd2, 2'd3);
    wait_addr(2'd0, 10, "play_wrap");
    check_tone(2'd3, 2'd0);
  endtask

  task automatic test_pause_resume();
    wait_addr(2'd1, 10, "pr_1");
    check_tone(2'd0, 2'd1);
    wait_addr(2'd2, 10, "pr_2");
    check_tone(2'd1, 2'd2);
    // Third cycle of address 2 carries the pause pulse
    pulse_play();
    n_checks++;
    if (playing !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_playing: got %b expected 0", playing);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (rom_addr !== 2'd2 || output_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL pause_hold cycle %0d: addr %0d oe %b expected 2 0",
                 i, rom_addr, output_enable);
      end
    end
    pulse_play();
    chg_cyc = cyc;
    wait_addr(2'd3, 7, "resume");
    check_tone(2'd2, 2'd3);
  endtask

  task automatic test_reverse_wrap();
    wait_addr(2'd0, 10, "rev_pre");
    check_tone(2'd3, 2'd0);
    repeat (7) tick();
    reverse = 1'b1;
    tick();
    reverse = 1'b0;
    n_checks++;
    if (rom_addr !== 2'd3 || reversed !== 1'b1) begin
      n_fail++;
      $display("FAIL rev_wrap: addr %0d reversed %b expected 3 1", rom_addr, reversed);
    end
    n_checks++;
    if (cyc - chg_cyc != 10) begin
      n_fail++;
      $display("FAIL rev_wrap length: got %0d expected 10", cyc - chg_cyc);
    end
    chg_cyc = cyc;
    wait_addr(2'd2, 10, "rev_next");
  endtask

  task automatic test_tempo_saturation();
    // Three up pulses: 10 -> 6 -> 2 -> 2; count 2 meets tempo 2 immediately
    tempo_up = 1'b1;
    repeat (3) tick();
    tempo_up = 1'b0;
    n_checks++;
    if (rom_addr !== 2'd1 || cyc - chg_cyc != 3) begin
      n_fail++;
      $display("FAIL tempo_up_step: addr %0d after %0d cycles expected 1 after 3",
               rom_addr, cyc - chg_cyc);
    end
    chg_cyc = cyc;
    wait_addr(2'd0, 2, "tempo_min_a");
    wait_addr(2'd3, 2, "tempo_min_b");
    wait_addr(2'd2, 2, "tempo_min_c");
    // Five down pulses: 6, 10, 14, 18, 18
    tempo_down = 1'b1;
    repeat (5) tick();
    tempo_down = 1'b0;
    wait_addr(2'd1, 18, "tempo_max_a");
    wait_addr(2'd0, 18, "tempo_max_b");
    // Simultaneous up and down leaves tempo at 18
    tempo_up = 1'b1;
    tempo_down = 1'b1;
    tick();
    tempo_up = 1'b0;
    tempo_down = 1'b0;
    wait_addr(2'd3, 18, "tempo_both");
    tempo_up = 1'b1;
    repeat (2) tick();
    tempo_up = 1'b0;
    wait_addr(2'd2, 10, "tempo_back_10");
  endtask

  task automatic test_tempo_shrink();
    // Count 8 with tempo 10, shrink to 6
    repeat (8) tick();
    tempo_up = 1'b1;
    tick();
    tempo_up = 1'b0;
    n_checks++;
    if (rom_addr !== 2'd2) begin
      n_fail++;
      $display("FAIL shrink_a early: got %0d expected 2", rom_addr);
    end
    tick();
    n_checks++;
    if (rom_addr !== 2'd1 || cyc - chg_cyc != 10) begin
      n_fail++;
      $display("FAIL shrink_a step: addr %0d after %0d expected 1 after 10",
               rom_addr, cyc - chg_cyc);
    end
    chg_cyc = cyc;
    // Count 3 with tempo 6, shrink to 2: step one cycle sooner than a full note
    repeat (3) tick();
    tempo_up = 1'b1;
    tick();
    tempo_up = 1'b0;
    n_checks++;
    if (rom_addr !== 2'd1) begin
      n_fail++;
      $display("FAIL shrink_b early: got %0d expected 1", rom_addr);
    end
    tick();
    n_checks++;
    if (rom_addr !== 2'd0 || cyc - chg_cyc != 5) begin
      n_fail++;
      $display("FAIL shrink_b step: addr %0d after %0d expected 0 after 5",
               rom_addr, cyc - chg_cyc);
    end
    chg_cyc = cyc;
  endtask

  task automatic test_mid_reset();
    tick();
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (rom_addr !== 2'd0 || tone_switch_period !== 24'd0 || output_enable !== 1'b0 ||
        playing !== 1'b0 || reversed !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: addr %0d tone %0d oe %b playing %b reversed %b",
               rom_addr, tone_switch_period, output_enable, playing, reversed);
    end
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (rom_addr !== 2'd0 || playing !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: addr %0d playing %b expected 0 0", rom_addr, playing);
    end
    pulse_play();
    chg_cyc = cyc;
    wait_addr(2'd1, 10, "post_reset_play");
  endtask

  initial begin
    rom_mem[0] = 24'd100;
    rom_mem[1] = 24'd0;
    rom_mem[2] = 24'd300;
    rom_mem[3] = 24'd400;
    play_pause = 1'b0;
    reverse    = 1'b0;
    tempo_up   = 1'b0;
    tempo_down = 1'b0;
    rst        = 1'b1;
    test_reset();
    test_play_wrap();
    test_pause_resume();
    test_reverse_wrap();
    test_tempo_saturation();
    test_tempo_shrink();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
